fc_obuf: RTL and testbench
==========================

Name: fc_obuf

Overview:
- Output-side accumulator for one fully-connected CIM tile column group.
- The crossbar is driven bit-serially, LSB plane first, by the next-layer-style input buffer. This block collects per-bit-plane partial sums and shift-adds them into full-precision dot products.
- It requantizes each dot product to DATA_SIZE bits and streams the results as FIFO_LENGTH write strobes. These strobes connect directly to the next layer's input buffer write port (i_we / i_data).

Parameters:
- DATA_SIZE, 8, activation/weight bit width; also the number of input bit-planes per operation.
- XBAR_SIZE, 128, crossbar rows.
- OBUF_BUS_WIDTH, 46, bus width budget used to derive NUM_CHANNELS.
- PSUM_WIDTH, DATA_SIZE+$clog2(XBAR_SIZE) (15), width of one per-plane partial sum.
- OBUF_DATA_SIZE, 2*DATA_SIZE+$clog2(XBAR_SIZE) (23), accumulator width.
- NUM_CHANNELS, floor(OBUF_BUS_WIDTH/OBUF_DATA_SIZE) (2), partial sums delivered per beat.
- FIFO_LENGTH, ceil(floor(XBAR_SIZE/DATA_SIZE)/NUM_CHANNELS) (8), beats (groups) per bit-plane.
- OUT_SHIFT, 8, right shift applied before saturation.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- i_valid, input, 1, partial-sum beat valid.
- o_ready, output, 1, block can accept a beat. Handshake occurs when i_valid && o_ready.
- i_psum, input, NUM_CHANNELS*PSUM_WIDTH, unsigned partial sums. Channel c is at bits [c*PSUM_WIDTH +: PSUM_WIDTH].
- o_we, output, 1, write strobe to the downstream input buffer.
- o_data, output, NUM_CHANNELS*DATA_SIZE, requantized results. Channel c is at bits [c*DATA_SIZE +: DATA_SIZE].
- o_done, output, 1, one-cycle pulse when the drain completes.
- o_busy, output, 1, high whenever an operation is in progress.

Behaviour:
- Reset is synchronous and active-high. The block uses one clock, clk.
- Reset values:
  - state=ACCUM, beat_cnt=0, plane_cnt=0, drain_idx=0.
  - o_we=0, o_data=0, o_done=0, o_busy=0, o_ready=1.
  - Accumulators are not reset.
- Storage: acc[FIFO_LENGTH][NUM_CHANNELS], each OBUF_DATA_SIZE bits wide.
- State ACCUM: o_ready=1. On each handshake:
  - If plane_cnt==0: acc[beat_cnt][c] <= psum_c. This overwrites, so no clear cycle is needed between operations.
  - Otherwise: acc[beat_cnt][c] <= acc[beat_cnt][c] + (psum_c << plane_cnt), computed at OBUF_DATA_SIZE width. Truncation cannot occur for legal inputs (max psum 32640, times 255, fits in 23 bits).
  - beat_cnt increments. When it wraps from FIFO_LENGTH-1 to 0, plane_cnt increments.
  - When the handshake is on the final beat (plane DATA_SIZE-1, beat FIFO_LENGTH-1): next state is DRAIN, drain_idx=FIFO_LENGTH-1, and both counters return to 0.
- Gaps in i_valid: no effect on counters or on the result.
- State DRAIN: o_ready=0; i_valid is ignored and its data is dropped.
  - Each cycle: o_we=1 and o_data channel c = sat(acc[drain_idx][c] >> OUT_SHIFT).
  - Then drain_idx decrements.
  - After drain_idx==0 is output, next state is DONE.
- Drain order: group FIFO_LENGTH-1 first, down to group 0. After FIFO_LENGTH shift-in writes, downstream FIFO slot k holds group k.
- Saturation (sat): if the shifted value > 2^DATA_SIZE-1, output all ones; otherwise output the low DATA_SIZE bits.
- State DONE: o_done=1 and o_ready=0 for one cycle, o_we=0, then next state is ACCUM.
- Timing, with the final handshake in cycle T:
  - o_we is high in cycles T+1 .. T+FIFO_LENGTH.
  - o_done is high in cycle T+FIFO_LENGTH+1.
  - o_ready returns high in cycle T+FIFO_LENGTH+2.
- Output derivation: o_data and o_we are combinational decode of registered state and drain_idx. o_data=0 whenever o_we=0.
- o_busy is high in DRAIN and in DONE, and in ACCUM whenever beat_cnt!=0 or plane_cnt!=0.
- rst asserted in any state aborts the operation. The reset values are visible the next cycle, including o_we=0 during DRAIN. A partially accumulated operation is discarded; the next operation's plane 0 overwrites the accumulators.
- rst has priority over a simultaneous handshake.

Test Plan:
1. Uniform load: all psums=256, every plane and beat -> acc=65280, >>8=255 -> 8 o_we cycles with o_data=0xFFFF. With psum=128 -> 32640>>8=127 -> o_data=0x7F7F on every beat.
2. Placement: only plane 3, group 5, channel 1 psum=100, all others 0 -> acc=800 -> 3. The 3rd o_we beat (drain beat 2, group 5) shows o_data=0x0300; all other beats show 0x0000.
3. Saturation/width: psum=32640 all planes, channel 0; psum=0 channel 1 -> acc=8323200 (no wrap in 23 bits) -> o_data=0x00FF on all 8 beats.
4. Stall and drop: random i_valid gaps over 64 beats give a result identical to scenario 1. Pulses of i_valid during DRAIN/DONE do not alter the result or the next op. o_done occurs exactly 9 cycles after the final handshake; o_ready is low for exactly 9 cycles.
5. Reset mid-op: rst after 3 planes -> o_busy=0 the next cycle. A following full op with psum=128 yields 0x7F7F. rst on the 4th drain cycle -> o_we=0 the next cycle, with no o_done.
6. Back-to-back: op A (psum=256) immediately followed by op B (psum=1) -> B outputs acc=255>>8=0 -> o_data=0x0000, with no residue from A.

Source files
------------

// File: rtl/fc_obuf.sv
// Output-side shift-add accumulator for one FC CIM column group: collects bit-plane
// partial sums, then drains requantized results highest group first into the next input buffer.
module fc_obuf #(
   parameter int DATA_SIZE      = 8,
   parameter int XBAR_SIZE      = 128,
   parameter int OBUF_BUS_WIDTH = 46,
   parameter int OUT_SHIFT      = 8,
   localparam int PSUM_WIDTH     = DATA_SIZE + $clog2(XBAR_SIZE),
   localparam int OBUF_DATA_SIZE = 2 * DATA_SIZE + $clog2(XBAR_SIZE),
   localparam int NUM_CHANNELS   = OBUF_BUS_WIDTH / OBUF_DATA_SIZE,
   localparam int FIFO_LENGTH    = ((XBAR_SIZE / DATA_SIZE) + NUM_CHANNELS - 1) / NUM_CHANNELS
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               i_valid,
   output logic                               o_ready,
   input  logic [NUM_CHANNELS*PSUM_WIDTH-1:0] i_psum,
   output logic                               o_we,
   output logic [NUM_CHANNELS*DATA_SIZE-1:0]  o_data,
   output logic                               o_done,
   output logic                               o_busy
);

   localparam int BEAT_W  = (FIFO_LENGTH > 1) ? $clog2(FIFO_LENGTH) : 1;
   localparam int PLANE_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

   localparam logic [BEAT_W-1:0]         BEAT_LAST  = BEAT_W'(FIFO_LENGTH - 1);
   localparam logic [PLANE_W-1:0]        PLANE_LAST = PLANE_W'(DATA_SIZE - 1);
   localparam logic [OBUF_DATA_SIZE-1:0] SAT_MAX    = OBUF_DATA_SIZE'((1 << DATA_SIZE) - 1);

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [PLANE_W-1:0]  plane_cnt_q, plane_cnt_d;
   logic [BEAT_W-1:0]   drain_idx_q, drain_idx_d;

   logic [OBUF_DATA_SIZE-1:0] acc_q [FIFO_LENGTH][NUM_CHANNELS];
   logic [OBUF_DATA_SIZE-1:0] psum_ext [NUM_CHANNELS];

   logic hs;
   logic last_beat;

   // Requantize: arithmetic right shift of a non-negative value, clamp to DATA_SIZE bits.
   function automatic logic [DATA_SIZE-1:0] sat(input logic [OBUF_DATA_SIZE-1:0] v);
      logic [OBUF_DATA_SIZE-1:0] s;
      s = v >> OUT_SHIFT;
      if (s > SAT_MAX) begin
         return '1;
      end
      return s[DATA_SIZE-1:0];
   endfunction

   assign hs        = i_valid && (state_q == ACCUM);
   assign last_beat = (plane_cnt_q == PLANE_LAST) && (beat_cnt_q == BEAT_LAST);

   always_comb begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         psum_ext[c] = OBUF_DATA_SIZE'(i_psum[c*PSUM_WIDTH +: PSUM_WIDTH]);
      end
   end

   // Plane 0 overwrites, so a new operation never needs a clear pass.
   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_acc
      always_ff @(posedge clk) begin
         if (!rst && hs) begin
            if (plane_cnt_q == '0) begin
               acc_q[beat_cnt_q][c] <= psum_ext[c];
            end else begin
               acc_q[beat_cnt_q][c] <= acc_q[beat_cnt_q][c] + (psum_ext[c] << plane_cnt_q);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ACCUM;
         beat_cnt_q  <= '0;
         plane_cnt_q <= '0;
         drain_idx_q <= '0;
      end else begin
         state_q     <= state_d;
         beat_cnt_q  <= beat_cnt_d;
         plane_cnt_q <= plane_cnt_d;
         drain_idx_q <= drain_idx_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      beat_cnt_d  = beat_cnt_q;
      plane_cnt_d = plane_cnt_q;
      drain_idx_d = drain_idx_q;
      case (state_q)
         ACCUM: begin
            if (hs) begin
               if (last_beat) begin
                  state_d     = DRAIN;
                  drain_idx_d = BEAT_LAST;
                  beat_cnt_d  = '0;
                  plane_cnt_d = '0;
               end else if (beat_cnt_q == BEAT_LAST) begin
                  beat_cnt_d  = '0;
                  plane_cnt_d = plane_cnt_q + 1'b1;
               end else begin
                  beat_cnt_d  = beat_cnt_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (drain_idx_q == '0) begin
               state_d = DONE;
            end else begin
               drain_idx_d = drain_idx_q - 1'b1;
            end
         end
         DONE: begin
            state_d = ACCUM;
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   // Highest group leaves first so the downstream shift-in FIFO ends with slot k = group k.
   always_comb begin
      o_data = '0;
      if (state_q == DRAIN) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            o_data[c*DATA_SIZE +: DATA_SIZE] = sat(acc_q[drain_idx_q][c]);
         end
      end
   end

   assign o_we    = (state_q == DRAIN);
   assign o_done  = (state_q == DONE);
   assign o_ready = (state_q == ACCUM);
   assign o_busy  = (state_q != ACCUM) || (beat_cnt_q != '0) || (plane_cnt_q != '0);

endmodule

// File: tb/tb_fc_obuf.sv
// Directed bench for fc_obuf: uniform loads, placement, saturation, stalls/drops,
// mid-operation reset and back-to-back operations.
module tb_fc_obuf;

   localparam int PW = 15;
   localparam int NC = 2;
   localparam int DW = 8;

   logic                clk = 1'b0;
   logic                rst;
   logic                i_valid;
   logic                o_ready;
   logic [NC*PW-1:0]    i_psum;
   logic                o_we;
   logic [NC*DW-1:0]    o_data;
   logic                o_done;
   logic                o_busy;

   int n_cmp  = 0;
   int n_fail = 0;

   fc_obuf dut (
      .clk     (clk),
      .rst     (rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_psum  (i_psum),
      .o_we    (o_we),
      .o_data  (o_data),
      .o_done  (o_done),
      .o_busy  (o_busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scenarios: 0 psum=256, 1 psum=128, 2 single placement, 3 ch0 max, 4 psum=1
   function automatic logic [PW-1:0] psum_of(int scen, int pl, int bt, int ch);
      case (scen)
         0:       return 15'd256;
         1:       return 15'd128;
         2:       return (pl == 3 && bt == 5 && ch == 1) ? 15'd100 : 15'd0;
         3:       return (ch == 0) ? 15'd32640 : 15'd0;
         default: return 15'd1;
      endcase
   endfunction

   // Hand-computed drain words per group.
   function automatic logic [15:0] exp_word(int scen, int grp);
      case (scen)
         0:       return 16'hFFFF;
         1:       return 16'h7F7F;
         2:       return (grp == 5) ? 16'h0300 : 16'h0000;
         3:       return 16'h00FF;
         default: return 16'h0000;
      endcase
   endfunction

   task automatic send_op(input int scen, input bit gaps, input int n_planes);
      for (int pl = 0; pl < n_planes; pl++) begin
         for (int bt = 0; bt < 8; bt++) begin
            if (gaps) begin
               repeat ($urandom_range(0, 2)) begin
                  i_valid = 1'b0;
                  i_psum  = 30'($urandom);
                  tick();
               end
            end
            i_valid = 1'b1;
            for (int c = 0; c < NC; c++) i_psum[c*PW +: PW] = psum_of(scen, pl, bt, c);
            tick();
            if (pl == 0 && bt == 0) chk("busy_accum", 32'(o_busy), 32'd1);
         end
      end
      i_valid = 1'b0;
      i_psum  = '0;
   endtask

   // Called in cycle T+1 after the final handshake.
   task automatic drain_check(input int scen, input bit pulses, input int abort_at);
      for (int k = 0; k < 8; k++) begin
         chk("drain_we",    32'(o_we),    32'd1);
         chk("drain_data",  32'(o_data),  32'(exp_word(scen, 7 - k)));
         chk("drain_ready", 32'(o_ready), 32'd0);
         chk("drain_busy",  32'(o_busy),  32'd1);
         chk("drain_done",  32'(o_done),  32'd0);
         if (k == abort_at) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk("abort_we",    32'(o_we),    32'd0);
            chk("abort_data",  32'(o_data),  32'd0);
            chk("abort_done",  32'(o_done),  32'd0);
            chk("abort_busy",  32'(o_busy),  32'd0);
            chk("abort_ready", 32'(o_ready), 32'd1);
            tick();
            chk("abort_nodone", 32'(o_done), 32'd0);
            return;
         end
         if (pulses) begin
            i_valid = 1'($urandom_range(0, 1));
            i_psum  = 30'($urandom);
         end
         tick();
      end
      chk("done_pulse", 32'(o_done),  32'd1);
      chk("done_we",    32'(o_we),    32'd0);
      chk("done_data",  32'(o_data),  32'd0);
      chk("done_ready", 32'(o_ready), 32'd0);
      if (pulses) begin
         i_valid = 1'b1;
         i_psum  = 30'($urandom);
      end
      tick();
      i_valid = 1'b0;
      i_psum  = '0;
      chk("idle_ready", 32'(o_ready), 32'd1);
      chk("idle_done",  32'(o_done),  32'd0);
      chk("idle_busy",  32'(o_busy),  32'd0);
   endtask

   initial begin
      rst     = 1'b1;
      i_valid = 1'b0;
      i_psum  = '0;
      tick();
      tick();
      chk("rst_we",    32'(o_we),    32'd0);
      chk("rst_data",  32'(o_data),  32'd0);
      chk("rst_done",  32'(o_done),  32'd0);
      chk("rst_busy",  32'(o_busy),  32'd0);
      chk("rst_ready", 32'(o_ready), 32'd1);
      rst = 1'b0;
      tick();

      // Uniform loads, placement, saturation
      send_op(0, 1'b0, 8); drain_check(0, 1'b0, -1);
      send_op(1, 1'b0, 8); drain_check(1, 1'b0, -1);
      send_op(2, 1'b0, 8); drain_check(2, 1'b0, -1);
      send_op(3, 1'b0, 8); drain_check(3, 1'b0, -1);

      // Stalls with drop pulses in drain/done, then an unaffected next op
      send_op(0, 1'b1, 8); drain_check(0, 1'b1, -1);
      send_op(1, 1'b0, 8); drain_check(1, 1'b0, -1);

      // Reset after three planes
      send_op(0, 1'b0, 3);
      chk("mid_busy", 32'(o_busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy",  32'(o_busy),  32'd0);
      chk("midrst_ready", 32'(o_ready), 32'd1);
      send_op(1, 1'b0, 8); drain_check(1, 1'b0, -1);

      // Reset on the 4th drain cycle
      send_op(0, 1'b0, 8); drain_check(0, 1'b0, 3);

      // Back-to-back A then B
      send_op(0, 1'b0, 8); drain_check(0, 1'b0, -1);
      send_op(4, 1'b0, 8); drain_check(4, 1'b0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
